regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with a per-register scoreboard and a decoupled flag register. It is the next-generation datapath register file: NR combinational read ports, NW write ports with fixed collision priority, optional write-to-read bypass, optional hardwired-zero r0, and busy tracking so the issue logic can stall on pending results. It sits between decode/issue and the ALU, and holds the Zero/Done machine flags.

## Interface
- W, 8: data width
- D, 4: address width; 2**D registers
- NR, 2: read ports, 1..4
- NW, 1: write ports, 1..2
- BYPASS, 1: 1 = same-cycle write data forwarded to reads
- ZERO_R0, 0: 1 = r0 reads 0, ignores writes and reservations
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- WriteEn  in  NW  per-port write enable
- Waddr  in  NW*D  write addresses, port p at [p*D +: D]
- DataIn  in  NW*W  write data, port p at [p*W +: W]
- Raddr  in  NR*D  read addresses
- DataOut  out  NR*W  read data, combinational
- Busy  out  NR  read port's register has a pending result
- ResvEn  in  1  mark ResvAddr busy
- ResvAddr  in  D  register to reserve
- BusyVec  out  2**D  raw scoreboard bits
- FlagWe  in  1  update flags
- Zero_in, Done_in  in  1 each  new flag values
- Zero_out, Done_out  out  1 each  flag register

## Operation
- Reset (async, immediate, regardless of Clk): all registers = 0, BusyVec = 0, Zero_out = 0, Done_out = 1 (machine halted). While Reset is high, all writes, reservations and flag updates are ignored.
- Write: at each rising edge where WriteEn[p] = 1, Registers[Waddr[p]] <= DataIn[p].
- Collision: if both ports write the same address, the higher-indexed port wins. Forwarding follows the same rule.
- Read: DataOut[r] = Registers[Raddr[r]]. If BYPASS = 1 and a write to Raddr[r] is enabled this cycle, DataOut[r] = the winning DataIn instead.
- ZERO_R0 = 1: reads of r0 return 0, including the bypass path. Writes and ResvEn to r0 are dropped, and BusyVec[0] stays 0.
- Scoreboard, per register, next busy bit in priority order:
  - ResvEn hits the register: 1. This wins over a simultaneous write; the new producer supersedes.
  - Any enabled write hits the register: 0.
  - Otherwise: hold.
- Busy[r] = BusyVec[Raddr[r]] & ~(BYPASS & write hit on Raddr[r] this cycle).
- Flags: on FlagWe, Zero_out <= Zero_in and Done_out <= Done_in. Flags are independent of WriteEn, so a flag update without a register write is legal.
- Address widths are exact. No out-of-range handling is needed.

## Timing
- Write-to-read latency is 1 cycle with BYPASS = 0 and 0 cycles (combinational) with BYPASS = 1.
- Reservation becomes visible on BusyVec/Busy the cycle after ResvEn.
- Write clears the busy bit on the same edge that stores the data.
- Flag latency is 1 cycle.
- No handshakes: every enabled write and reservation is accepted unconditionally.
- Reset deassertion is synchronised externally. The first enabled edge after deassertion acts normally.

## Structure
- Package `regfile_pkg`: default W/D constants, `FLAG_RESET_DONE = 1'b1`, reset-value constants, and a typedef for the flag pair (`flags_t` with `zero`, `done`).
- Sub-module `regfile_read_port`, instantiated NR times via generate: it takes the register array, write buses and scoreboard, and produces DataOut[r] and Busy[r], covering address mux, bypass priority, the r0 rule and busy masking.
- Top holds the storage, scoreboard, flag register and async reset.

## Test plan
- Reset: pulse Reset mid-cycle with registers loaded → immediately all DataOut = 0, BusyVec = 0, Zero_out = 0, Done_out = 1, with no clock edge needed.
- Write/read, BYPASS = 0: write 0xA5 to r3 → DataOut of a port reading r3 shows old 0x00 that cycle and 0xA5 the next. With BYPASS = 1 it shows 0xA5 in the same cycle.
- Collision, NW = 2: both ports write r5 (0x11 on port 0, 0x22 on port 1) → r5 = 0x22, and bypass also returns 0x22.
- Scoreboard:
  - ResvEn r7 → BusyVec[7] = 1 the next cycle.
  - Later write r7 = 0x3C → Busy deasserts, same cycle with BYPASS = 1 or next cycle with BYPASS = 0.
  - ResvEn and write to r7 in the same cycle → BusyVec[7] stays 1, r7 = written value.
- ZERO_R0 = 1: write 0xFF to r0 and ResvEn r0 → DataOut = 0x00, BusyVec[0] = 0.
- Flags: FlagWe with Zero_in = 1, Done_in = 0 and WriteEn = 0 → next cycle Zero_out = 1, Done_out = 0, and register contents are unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the multi-port register file.
//   - W_DEFAULT / D_DEFAULT : default data and address widths
//   - FLAG_RESET_ZERO/DONE  : reset values of the machine flags
//   - BUSY_RESET            : reset value of every scoreboard bit
//   - flags_t               : the Zero/Done flag pair held by the top
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int W_DEFAULT = 8;
  localparam int D_DEFAULT = 4;

  // The machine comes out of reset halted: Done set, Zero clear.
  localparam logic FLAG_RESET_ZERO = 1'b0;
  localparam logic FLAG_RESET_DONE = 1'b1;

  localparam logic BUSY_RESET = 1'b0;

  typedef struct packed {
    logic zero;
    logic done;
  } flags_t;

  localparam flags_t FLAGS_RESET = '{zero: FLAG_RESET_ZERO, done: FLAG_RESET_DONE};

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
//   One combinational read port of regfile_mp.
//   Ports:
//     regs      in  whole register array, entry i = register i
//     write_en  in  per-write-port enable, already qualified by the top
//                   (reset gated, r0 writes dropped when ZERO_R0 = 1)
//     waddr     in  write addresses, port p at [p*D +: D]
//     data_in   in  write data, port p at [p*W +: W]
//     busy_vec  in  raw scoreboard, bit i = register i pending
//     raddr     in  address read by this port
//     data_out  out register value, forwarded write data, or 0 for r0
//     busy      out pending-result flag for raddr, cleared by a bypassed write
// ---------------------------------------------------------------------------
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int D       = D_DEFAULT,
  parameter int NW      = 1,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic [2**D-1:0][W-1:0] regs,
  input  logic [NW-1:0]          write_en,
  input  logic [NW*D-1:0]        waddr,
  input  logic [NW*W-1:0]        data_in,
  input  logic [2**D-1:0]        busy_vec,
  input  logic [D-1:0]           raddr,
  output logic [W-1:0]           data_out,
  output logic                   busy
);

  localparam bit BYPASS_ON  = (BYPASS != 0);
  localparam bit ZERO_R0_ON = (ZERO_R0 != 0);

  logic         hit;      // some enabled write targets raddr this cycle
  logic [W-1:0] fwd_data; // data of the winning (highest-indexed) writer
  logic         use_fwd;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; that keeps the block free of inferred latches.
    hit      = 1'b0;
    fwd_data = '0;
    // Ascending scan: a later match overwrites an earlier one, so the
    // highest-indexed port wins exactly as it does in storage.
    for (int p = 0; p < NW; p++) begin
      if (write_en[p] && (waddr[p*D +: D] == raddr)) begin
        hit      = 1'b1;
        fwd_data = data_in[p*W +: W];
      end
    end
  end

  assign use_fwd = BYPASS_ON && hit;

  always_comb begin
    data_out = use_fwd ? fwd_data : regs[raddr];
    // r0 is hardwired to zero on both the stored and the forwarded path.
    if (ZERO_R0_ON && (raddr == '0)) begin
      data_out = '0;
    end
  end

  // A bypassed write delivers the result this cycle, so the reader need not
  // stall even though the scoreboard bit only clears at the edge.
  assign busy = busy_vec[raddr] & ~use_fwd;

endmodule : regfile_read_port

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Multi-port register file with per-register scoreboard and Zero/Done flags.
//   Ports:
//     Clk, Reset   rising-edge clock, asynchronous active-high reset
//     WriteEn      NW write enables
//     Waddr        NW write addresses, port p at [p*D +: D]
//     DataIn       NW write data words, port p at [p*W +: W]
//     Raddr        NR read addresses, port r at [r*D +: D]
//     DataOut      NR combinational read data words
//     Busy         NR pending-result flags, one per read port
//     ResvEn       reserve (mark busy) register ResvAddr
//     ResvAddr     register to reserve
//     BusyVec      raw scoreboard, bit i = register i pending
//     FlagWe       load Zero_in / Done_in into the flag register
//     Zero_in/out  Zero flag input / registered output
//     Done_in/out  Done flag input / registered output
//   Write collisions resolve to the highest-indexed port. A reservation
//   beats a write to the same register on the same edge.
// ---------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int D       = D_DEFAULT,
  parameter int NR      = 2,
  parameter int NW      = 1,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NW-1:0]     WriteEn,
  input  logic [NW*D-1:0]   Waddr,
  input  logic [NW*W-1:0]   DataIn,
  input  logic [NR*D-1:0]   Raddr,
  output logic [NR*W-1:0]   DataOut,
  output logic [NR-1:0]     Busy,
  input  logic              ResvEn,
  input  logic [D-1:0]      ResvAddr,
  output logic [2**D-1:0]   BusyVec,
  input  logic              FlagWe,
  input  logic              Zero_in,
  input  logic              Done_in,
  output logic              Zero_out,
  output logic              Done_out
);

  localparam int NREG       = 2**D;
  localparam bit ZERO_R0_ON = (ZERO_R0 != 0);

  logic [NREG-1:0][W-1:0] regs;
  logic [NREG-1:0]        busy_vec;
  logic [NREG-1:0]        busy_next;
  logic [NW-1:0]          wr_act;   // write enables that really take effect
  logic                   resv_act; // reservation that really takes effect
  flags_t                 flags;

  // Qualified enables: nothing is accepted while Reset is high, and writes or
  // reservations aimed at a hardwired r0 are dropped. The read ports see the
  // same qualified enables so bypass never forwards a dropped write.
  always_comb begin
    for (int p = 0; p < NW; p++) begin
      wr_act[p] = WriteEn[p] && !Reset &&
                  !(ZERO_R0_ON && (Waddr[p*D +: D] == '0));
    end
  end

  assign resv_act = ResvEn && !Reset && !(ZERO_R0_ON && (ResvAddr == '0));

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // NOTE: the register array is reset because the architecture defines every
  // register as zero after reset; that rules out mapping it onto a RAM macro.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so each port's
    // write samples pre-edge values and the last assignment wins cleanly.
    if (Reset) begin
      regs <= '0;
    end else begin
      // Ascending order: a higher-indexed port's write to the same address
      // is scheduled last and therefore wins.
      for (int p = 0; p < NW; p++) begin
        if (wr_act[p]) begin
          regs[Waddr[p*D +: D]] <= DataIn[p*W +: W];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard: reservation > write-clear > hold
  // -------------------------------------------------------------------------
  always_comb begin
    busy_next = busy_vec;
    for (int p = 0; p < NW; p++) begin
      if (wr_act[p]) begin
        busy_next[Waddr[p*D +: D]] = 1'b0;
      end
    end
    // Applied after the clears: a new producer supersedes a completing one.
    if (resv_act) begin
      busy_next[ResvAddr] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy_vec <= {NREG{BUSY_RESET}};
    end else begin
      busy_vec <= busy_next;
    end
  end

  assign BusyVec = busy_vec;

  // -------------------------------------------------------------------------
  // Flag register, independent of the register write ports
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      flags <= FLAGS_RESET;
    end else if (FlagWe) begin
      flags <= '{zero: Zero_in, done: Done_in};
    end
  end

  assign Zero_out = flags.zero;
  assign Done_out = flags.done;

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  for (genvar r = 0; r < NR; r++) begin : g_rd
    regfile_read_port #(
      .W       (W),
      .D       (D),
      .NW      (NW),
      .BYPASS  (BYPASS),
      .ZERO_R0 (ZERO_R0)
    ) u_rd (
      .regs     (regs),
      .write_en (wr_act),
      .waddr    (Waddr),
      .data_in  (DataIn),
      .busy_vec (busy_vec),
      .raddr    (Raddr[r*D +: D]),
      .data_out (DataOut[r*W +: W]),
      .busy     (Busy[r])
    );
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Two instances share one stimulus stream:
//     inst 0: NW=2, NR=2, BYPASS=0, ZERO_R0=0
//     inst 1: NW=2, NR=2, BYPASS=1, ZERO_R0=1
//   A behavioural model (plain arrays) predicts every output; a compare
//   process checks both instances on every falling edge. Directed steps add
//   hand-computed literal expectations, then a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int W = 8;
  localparam int D = 4;
  localparam int NREG = 16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  WriteEn;
  logic [7:0]  Waddr;
  logic [15:0] DataIn;
  logic [7:0]  Raddr;
  logic        ResvEn;
  logic [3:0]  ResvAddr;
  logic        FlagWe;
  logic        Zero_in;
  logic        Done_in;

  logic [15:0] dout [2];
  logic [1:0]  busy [2];
  logic [15:0] bvec [2];
  logic        zf   [2];
  logic        df   [2];

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 Clk = ~Clk;

  regfile_mp #(.W(W), .D(D), .NR(2), .NW(2), .BYPASS(0), .ZERO_R0(0)) u_a (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .Raddr(Raddr), .DataOut(dout[0]), .Busy(busy[0]), .ResvEn(ResvEn),
    .ResvAddr(ResvAddr), .BusyVec(bvec[0]), .FlagWe(FlagWe), .Zero_in(Zero_in),
    .Done_in(Done_in), .Zero_out(zf[0]), .Done_out(df[0])
  );

  regfile_mp #(.W(W), .D(D), .NR(2), .NW(2), .BYPASS(1), .ZERO_R0(1)) u_b (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .Raddr(Raddr), .DataOut(dout[1]), .Busy(busy[1]), .ResvEn(ResvEn),
    .ResvAddr(ResvAddr), .BusyVec(bvec[1]), .FlagWe(FlagWe), .Zero_in(Zero_in),
    .Done_in(Done_in), .Zero_out(zf[1]), .Done_out(df[1])
  );

  // ------------------------------------------------------------------ model
  logic [7:0] m_reg  [2][NREG];
  bit         m_busy [2][NREG];
  bit         m_zero, m_done;

  function automatic bit byp(int i);  return (i == 1); endfunction
  function automatic bit zr0(int i);  return (i == 1); endfunction
  function automatic logic [3:0] wa(int p); return Waddr[p*4 +: 4]; endfunction
  function automatic logic [3:0] ra(int r); return Raddr[r*4 +: 4]; endfunction

  // {hit, data} of the write that lands on address a this cycle (port 1 first).
  function automatic logic [8:0] fwd(logic [3:0] a);
    if (Reset) return 9'h0;
    if (WriteEn[1] && wa(1) == a) return {1'b1, DataIn[15:8]};
    if (WriteEn[0] && wa(0) == a) return {1'b1, DataIn[7:0]};
    return 9'h0;
  endfunction

  function automatic logic [7:0] exp_data(int i, int r);
    logic [3:0] a;
    logic [8:0] f;
    a = ra(r);
    f = fwd(a);
    if (zr0(i) && a == 4'd0) return 8'h00;
    if (byp(i) && f[8]) return f[7:0];
    return m_reg[i][a];
  endfunction

  function automatic logic exp_busy(int i, int r);
    logic [3:0] a;
    logic [8:0] f;
    a = ra(r);
    f = fwd(a);
    return m_busy[i][a] && !(byp(i) && f[8]);
  endfunction

  function automatic logic [15:0] exp_bvec(int i);
    logic [15:0] v;
    for (int k = 0; k < NREG; k++) v[k] = m_busy[i][k];
    return v;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < NREG; k++) begin
          m_reg[i][k]  = 8'h00;
          m_busy[i][k] = 1'b0;
        end
      m_zero = 1'b0;
      m_done = 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        // Port 0 first, port 1 second: the later write is the surviving one.
        for (int p = 0; p < 2; p++)
          if (WriteEn[p] && !(zr0(i) && wa(p) == 4'd0)) begin
            m_reg[i][wa(p)]  = DataIn[p*8 +: 8];
            m_busy[i][wa(p)] = 1'b0;
          end
        if (ResvEn && !(zr0(i) && ResvAddr == 4'd0)) m_busy[i][ResvAddr] = 1'b1;
      end
      if (FlagWe) begin
        m_zero = Zero_in;
        m_done = Done_in;
      end
    end
  end

  // ---------------------------------------------------------------- checking
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < 2; r++) begin
          check($sformatf("model dout i%0d r%0d", i, r),
                32'(dout[i][r*8 +: 8]), 32'(exp_data(i, r)));
          check($sformatf("model busy i%0d r%0d", i, r),
                32'(busy[i][r]), 32'(exp_busy(i, r)));
        end
        check($sformatf("model busyvec i%0d", i), 32'(bvec[i]), 32'(exp_bvec(i)));
        check($sformatf("model zero i%0d", i), 32'(zf[i]), 32'(m_zero));
        check($sformatf("model done i%0d", i), 32'(df[i]), 32'(m_done));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    WriteEn = 2'b00;
    ResvEn  = 1'b0;
    FlagWe  = 1'b0;
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    Reset = 1'b1;
    WriteEn = 2'b00; Waddr = 8'h00; DataIn = 16'h0000; Raddr = 8'h00;
    ResvEn = 1'b0; ResvAddr = 4'h0; FlagWe = 1'b0; Zero_in = 1'b0; Done_in = 1'b0;
    tick();
    chk_on = 1'b1;
    tick();
    @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset dout i%0d", i), 32'(dout[i]), 32'h0);
      check($sformatf("reset busyvec i%0d", i), 32'(bvec[i]), 32'h0);
      check($sformatf("reset done i%0d", i), 32'(df[i]), 32'h1);
      check($sformatf("reset zero i%0d", i), 32'(zf[i]), 32'h0);
    end
    tick();
    Reset = 1'b0;

    // Write 0xA5 to r3: registered read sees it next cycle, bypass now.
    WriteEn = 2'b01; Waddr = 8'h03; DataIn = 16'h00A5; Raddr = 8'h33;
    @(negedge Clk);
    check("wr r3 nobyp same", 32'(dout[0][7:0]), 32'h00);
    check("wr r3 byp same", 32'(dout[1][7:0]), 32'hA5);
    tick(); idle();
    @(negedge Clk);
    check("wr r3 nobyp next", 32'(dout[0][7:0]), 32'hA5);

    // Collision on r5: port 1 wins in storage and in forwarding.
    tick();
    WriteEn = 2'b11; Waddr = 8'h55; DataIn = 16'h2211; Raddr = 8'h53;
    @(negedge Clk);
    check("collide byp", 32'(dout[1][15:8]), 32'h22);
    tick(); idle();
    @(negedge Clk);
    check("collide stored", 32'(dout[0][15:8]), 32'h22);

    // Reserve r7, then complete it.
    tick();
    ResvEn = 1'b1; ResvAddr = 4'd7; Raddr = 8'h77;
    tick(); idle();
    @(negedge Clk);
    check("resv busyvec a", 32'(bvec[0][7]), 32'h1);
    check("resv busyvec b", 32'(bvec[1][7]), 32'h1);
    check("resv busy a", 32'(busy[0][0]), 32'h1);
    tick();
    WriteEn = 2'b01; Waddr = 8'h07; DataIn = 16'h003C;
    @(negedge Clk);
    check("wr r7 busy byp", 32'(busy[1][0]), 32'h0);
    check("wr r7 busy nobyp", 32'(busy[0][0]), 32'h1);
    tick(); idle();
    @(negedge Clk);
    check("wr r7 busy nobyp next", 32'(busy[0][0]), 32'h0);
    check("wr r7 data", 32'(dout[0][7:0]), 32'h3C);

    // Reservation and write to r7 on the same edge.
    tick();
    WriteEn = 2'b01; Waddr = 8'h07; DataIn = 16'h005A; ResvEn = 1'b1; ResvAddr = 4'd7;
    tick(); idle();
    @(negedge Clk);
    check("resv+wr busyvec a", 32'(bvec[0][7]), 32'h1);
    check("resv+wr busyvec b", 32'(bvec[1][7]), 32'h1);
    check("resv+wr data", 32'(dout[0][7:0]), 32'h5A);

    // r0: hardwired zero in inst 1, ordinary register in inst 0.
    tick();
    WriteEn = 2'b01; Waddr = 8'h00; DataIn = 16'h00FF; ResvEn = 1'b1; ResvAddr = 4'd0;
    Raddr = 8'h30;
    @(negedge Clk);
    check("r0 byp zero", 32'(dout[1][7:0]), 32'h00);
    tick(); idle();
    @(negedge Clk);
    check("r0 data zr0", 32'(dout[1][7:0]), 32'h00);
    check("r0 busyvec zr0", 32'(bvec[1][0]), 32'h0);
    check("r0 data plain", 32'(dout[0][7:0]), 32'hFF);
    check("r0 busyvec plain", 32'(bvec[0][0]), 32'h1);

    // Flags without a register write.
    tick();
    FlagWe = 1'b1; Zero_in = 1'b1; Done_in = 1'b0;
    tick(); idle();
    @(negedge Clk);
    check("flag zero", 32'(zf[0]), 32'h1);
    check("flag done", 32'(df[1]), 32'h0);
    check("flag regs kept", 32'(dout[0][15:8]), 32'hA5);

    // Asynchronous reset in the middle of a cycle.
    tick();
    #2 Reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("async rst dout i%0d", i), 32'(dout[i]), 32'h0);
      check($sformatf("async rst busyvec i%0d", i), 32'(bvec[i]), 32'h0);
      check($sformatf("async rst zero i%0d", i), 32'(zf[i]), 32'h0);
      check($sformatf("async rst done i%0d", i), 32'(df[i]), 32'h1);
    end
    tick();
    Reset = 1'b0;

    // Randomized phase.
    for (int c = 0; c < 2000; c++) begin
      Reset   = 1'b0;
      WriteEn = 2'($urandom);
      Waddr   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) Waddr[7:4] = Waddr[3:0];
      if ($urandom_range(0, 3) == 0) Waddr[3:0] = 4'd0;
      DataIn  = 16'($urandom);
      Raddr   = 8'($urandom);
      if ($urandom_range(0, 2) == 0) Raddr[3:0] = Waddr[3:0];
      if ($urandom_range(0, 2) == 0) Raddr[7:4] = Waddr[7:4];
      ResvEn   = ($urandom_range(0, 3) == 0);
      ResvAddr = ($urandom_range(0, 1) == 0) ? Waddr[3:0] : 4'($urandom);
      FlagWe   = ($urandom_range(0, 3) == 0);
      Zero_in  = 1'($urandom);
      Done_in  = 1'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 Reset = 1'b1;
      end
      tick();
    end

    Reset = 1'b0;
    idle();
    tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_mp
